// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU front end: opcodes, instruction field
// positions, decoded field struct and the issue sequencer state encoding.
package cpu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    // Instruction word: [15:13] opcode, [12:11] rd, [10:9] rs, [8] imm_sel, [7:0] imm
    localparam int OPC_LSB     = 13;
    localparam int RD_LSB      = 11;
    localparam int RS_LSB      = 9;
    localparam int IMM_SEL_BIT = 8;
    localparam int IMM_LSB     = 0;

    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] rd;
        logic [1:0] rs;
        logic       imm_sel;
        logic [7:0] imm;
    } instr_fields_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT      = 3'd3,
        ST_DONE      = 3'd4,
        ST_STEP_HOLD = 3'd5
    } seq_state_t;

    function automatic logic is_multi_cycle(input logic [7:0] mask, input logic [2:0] opc);
        return mask[opc];
    endfunction

endpackage

// File: rtl/instr_issue_seq_if.sv
// Bus bundle between the issue sequencer, program memory and the control/ALU side.
interface instr_issue_seq_if #(
    parameter int ADDR_W = 8
);
    // imem: imem_req is the valid, held until imem_ack (the ready) is seen high in
    // the same cycle; ack may coincide with the first req cycle, ack while req=0 is
    // meaningless. Issue: op_valid is a one-cycle pulse with no back-pressure;
    // alu_done is the completion pulse for multi-cycle opcodes.
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [15:0]       imem_rdata;
    logic [2:0]        opcode;
    logic [1:0]        rd;
    logic [1:0]        rs;
    logic              imm_sel;
    logic [7:0]        imm;
    logic              op_valid;
    logic              alu_done;

    modport master (
        output imem_req, imem_addr, opcode, rd, rs, imm_sel, imm, op_valid,
        input  imem_ack, imem_rdata, alu_done
    );

    modport slave (
        input  imem_req, imem_addr, opcode, rd, rs, imm_sel, imm, op_valid,
        output imem_ack, imem_rdata, alu_done
    );
endinterface

// File: rtl/instr_field_split.sv
// Combinational split of a 16-bit instruction word into its decoded fields.
module instr_field_split
    import cpu_pkg::*;
(
    input  logic [15:0]   i_word,
    output instr_fields_t o_fields
);
    always_comb begin
        o_fields.opcode  = i_word[OPC_LSB +: 3];
        o_fields.rd      = i_word[RD_LSB +: 2];
        o_fields.rs      = i_word[RS_LSB +: 2];
        o_fields.imm_sel = i_word[IMM_SEL_BIT];
        o_fields.imm     = i_word[IMM_LSB +: 8];
    end
endmodule

// File: rtl/instr_issue_seq.sv
// Instruction fetch/issue sequencer feeding control_unit; stalls on multi-cycle ALU ops.
// Optional single-step mode (STEP_HOLD state, step input) enabled by SINGLE_STEP_EN.
module instr_issue_seq
    import cpu_pkg::*;
#(
    parameter int              ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}},
    parameter logic [7:0]      MC_MASK   = (8'b1 << OP_MUL) | (8'b1 << OP_DIV)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef SINGLE_STEP_EN
    input  logic               step,
`endif
    instr_issue_seq_if.master  bus,
    output logic               busy,
    output logic               done,
    output seq_state_t         o_dbg_state
);
    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    seq_state_t        r_state;
    seq_state_t        w_next_state;
    seq_state_t        w_adv_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_next_pc;
    logic [ADDR_W-1:0] w_adv_pc;
    instr_fields_t     r_fields;
    instr_fields_t     w_fetched;
    logic              w_last;
    logic              w_mc;

    instr_field_split u_split (
        .i_word   (bus.imem_rdata),
        .o_fields (w_fetched)
    );

    assign w_last = (r_pc == LAST_ADDR);
    assign w_mc   = is_multi_cycle(MC_MASK, r_fields.opcode);

    // Where execution goes once the current instruction has retired.
    always_comb begin
        if (w_last) begin
            w_adv_state = ST_DONE;
            w_adv_pc    = r_pc;
        end else begin
            w_adv_state = ST_FETCH;
            w_adv_pc    = r_pc + PC_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_pc     <= '0;
            r_fields <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            if (r_state == ST_FETCH && bus.imem_ack) begin
                r_fields <= w_fetched;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_next_state = ST_FETCH;
                    w_next_pc    = '0;
                end
            end
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_mc) begin
                    w_next_state = ST_WAIT;
                end else begin
`ifdef SINGLE_STEP_EN
                    w_next_state = ST_STEP_HOLD;
`else
                    w_next_state = w_adv_state;
                    w_next_pc    = w_adv_pc;
`endif
                end
            end
            ST_WAIT: begin
                if (bus.alu_done) begin
`ifdef SINGLE_STEP_EN
                    w_next_state = ST_STEP_HOLD;
`else
                    w_next_state = w_adv_state;
                    w_next_pc    = w_adv_pc;
`endif
                end
            end
`ifdef SINGLE_STEP_EN
            // pc is untouched while holding, so the deferred transition is recomputed here.
            ST_STEP_HOLD: begin
                if (step) begin
                    w_next_state = w_adv_state;
                    w_next_pc    = w_adv_pc;
                end
            end
`endif
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign bus.imem_req  = (r_state == ST_FETCH);
    assign bus.imem_addr = r_pc;
    assign bus.opcode    = r_fields.opcode;
    assign bus.rd        = r_fields.rd;
    assign bus.rs        = r_fields.rs;
    assign bus.imm_sel   = r_fields.imm_sel;
    assign bus.imm       = r_fields.imm;
    assign bus.op_valid  = (r_state == ST_ISSUE);
    assign busy          = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done          = (r_state == ST_DONE);
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_instr_issue_seq.sv
// Self-checking bench for instr_issue_seq: randomized programs and handshake
// timing checked against an in-order issue model of the program image.
module tb_instr_issue_seq;
    import cpu_pkg::*;

    localparam int         ADDR_W = 8;
    localparam logic [7:0] LAST   = 8'd3;
    localparam logic [7:0] MC     = 8'b0110_0000;
`ifdef SINGLE_STEP_EN
    localparam int STEP_EXTRA = 1;
`else
    localparam int STEP_EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
`ifdef SINGLE_STEP_EN
    logic       step;
`endif
    logic       busy;
    logic       done;
    seq_state_t dbg_state;

    logic [15:0] prog [0:255];
    logic [15:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    instr_issue_seq_if #(.ADDR_W(ADDR_W)) ifc ();

    instr_issue_seq #(
        .ADDR_W    (ADDR_W),
        .LAST_ADDR (LAST),
        .MC_MASK   (MC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
`ifdef SINGLE_STEP_EN
        .step        (step),
`endif
        .bus         (ifc),
        .busy        (busy),
        .done        (done),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Runs the program image from address 0 to LAST. Expected issue order is the
    // image itself; expected fetch gap is 1 cycle, or alu delay + 2 for mul/div.
    task automatic run_program(input int ack_min, input int ack_max,
                               input int alu_min, input int alu_max, input bit start_noise);
        int          ack_cnt, alu_cnt, issued, gap_exp, gap_cnt, first_ack, opc;
        bit          pending, ack_prev, gap_armed;
        logic [15:0] w, got;
        exp_q.delete();
        for (int a = 0; a <= int'(LAST); a++) exp_q.push_back(prog[a]);
        ack_cnt = $urandom_range(ack_max, ack_min);
        first_ack = ack_cnt;
        alu_cnt = 0; issued = 0; gap_exp = 0; gap_cnt = 0;
        pending = 0; ack_prev = 0; gap_armed = 0;
`ifdef SINGLE_STEP_EN
        step = 1'b1;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 2000 && done !== 1'b1; cyc++) begin
            if (ack_prev) begin
                n_vec++;
                if (ifc.op_valid !== 1'b1) begin
                    n_err++; $display("FAIL issue_latency: op_valid=%b required 1 the cycle after ack", ifc.op_valid);
                end
            end
            if (ifc.op_valid === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL extra_issue: op_valid with no instruction left");
                end else begin
                    w   = exp_q.pop_front();
                    got = {ifc.opcode, ifc.rd, ifc.rs, ifc.imm_sel, ifc.imm};
                    if (got !== w) begin
                        n_err++; $display("FAIL issue_fields: got %h required %h", got, w);
                    end
                    if (issued == 0) begin
                        n_vec++;
                        if (cyc != first_ack + 1) begin
                            n_err++; $display("FAIL first_issue_cycle: got %0d required %0d", cyc, first_ack + 1);
                        end
                    end
                    opc = int'(w) / 8192;
                    if (((int'(MC) >> opc) & 1) == 1) begin
                        pending = 1;
                        alu_cnt = $urandom_range(alu_max, alu_min);
                        gap_exp = alu_cnt + 2 + STEP_EXTRA;
                    end else begin
                        gap_exp = 1 + STEP_EXTRA;
                    end
                    gap_armed = (exp_q.size() != 0);
                    gap_cnt = 0;
                    issued++;
                end
            end else if (gap_armed) begin
                gap_cnt++;
                if (ifc.imem_req === 1'b1 || gap_cnt > gap_exp) begin
                    n_vec++;
                    if (gap_cnt != gap_exp || ifc.imem_req !== 1'b1) begin
                        n_err++; $display("FAIL fetch_gap: req after %0d cycles required %0d", gap_cnt, gap_exp);
                    end
                    gap_armed = 0;
                end
            end
            ack_prev = 0;
            ifc.imem_ack = 1'b0;
            ifc.imem_rdata = 16'($urandom);
            ifc.alu_done = 1'b0;
            if (ifc.imem_req === 1'b1) begin
                if (ack_cnt == 0) begin
                    n_vec++;
                    if (ifc.imem_addr !== 8'(issued)) begin
                        n_err++; $display("FAIL fetch_addr: got %0d required %0d", ifc.imem_addr, issued);
                    end
                    ifc.imem_ack = 1'b1;
                    ifc.imem_rdata = prog[ifc.imem_addr];
                    ack_prev = 1;
                    ack_cnt = $urandom_range(ack_max, ack_min);
                end else begin
                    ack_cnt--;
                end
            end else if ($urandom_range(3, 0) == 0) begin
                ifc.imem_ack = 1'b1;
            end
            if (pending && ifc.op_valid !== 1'b1) begin
                if (alu_cnt == 0) begin
                    ifc.alu_done = 1'b1;
                    pending = 0;
                end else begin
                    alu_cnt--;
                end
            end else if (!pending && ifc.op_valid !== 1'b1 && $urandom_range(3, 0) == 0) begin
                ifc.alu_done = 1'b1;
            end
            start = (start_noise && busy === 1'b1 && $urandom_range(7, 0) == 0);
            @(negedge clk);
        end
        ifc.imem_ack = 1'b0;
        ifc.alu_done = 1'b0;
        start = 1'b0;
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL completion: done=%b busy=%b required done=1 busy=0", done, busy);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL issue_count: %0d instructions never issued, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        ifc.imem_ack = 1'b0; ifc.imem_rdata = 16'h0; ifc.alu_done = 1'b0;
`ifdef SINGLE_STEP_EN
        step = 1'b0;
`endif
        repeat (3) @(negedge clk);
        n_vec++;
        if ({ifc.imem_req, ifc.imem_addr, ifc.opcode, ifc.rd, ifc.rs, ifc.imm_sel, ifc.imm,
             ifc.op_valid, busy, done} !== 29'h0) begin
            n_err++; $display("FAIL reset_outputs: req=%b addr=%h opc=%b imm=%h valid=%b busy=%b done=%b required all 0",
                              ifc.imem_req, ifc.imem_addr, ifc.opcode, ifc.imm, ifc.op_valid, busy, done);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_first_issue();
        prog[0] = 16'h0000;
        for (int a = 1; a <= int'(LAST); a++) prog[a] = {3'b000, 13'($urandom)};
        run_program(0, 0, 0, 0, 0);
    endtask

    task automatic test_multi_cycle();
        prog[0] = 16'hA1C3;
        for (int a = 1; a <= int'(LAST); a++) prog[a] = {3'b011, 13'($urandom)};
        run_program(0, 0, 4, 4, 0);
    endtask

    task automatic test_last_addr();
        for (int a = 0; a <= int'(LAST); a++) prog[a] = {3'b000, 13'($urandom)};
        run_program(2, 2, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a <= int'(LAST); a++) prog[a] = {3'($urandom_range(4, 0)), 13'($urandom)};
        run_program(0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            for (int a = 0; a <= int'(LAST); a++) prog[a] = 16'($urandom);
            run_program(0, 3, 0, 3, 1);
        end
    endtask

    task automatic test_reset_mid_fetch();
        bit hit = 0;
        prog[0] = 16'h7E5A;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 50 && !hit; cyc++) begin
            ifc.imem_ack = 1'b0;
            if (ifc.imem_req === 1'b1 && ifc.imem_addr === 8'd1) begin
                ifc.imem_ack = 1'b1; ifc.imem_rdata = 16'hFFFF; rst = 1'b1; hit = 1;
            end else if (ifc.imem_req === 1'b1) begin
                ifc.imem_ack = 1'b1; ifc.imem_rdata = prog[ifc.imem_addr];
            end
            @(negedge clk);
        end
        rst = 1'b0; ifc.imem_ack = 1'b0;
        n_vec++;
        if (!hit || {ifc.imem_req, ifc.imem_addr, ifc.opcode, ifc.rd, ifc.rs, ifc.imm_sel, ifc.imm,
                     ifc.op_valid, busy, done} !== 29'h0) begin
            n_err++; $display("FAIL reset_mid_fetch: reached=%b req=%b addr=%h opc=%b imm=%h valid=%b busy=%b required all 0",
                              hit, ifc.imem_req, ifc.imem_addr, ifc.opcode, ifc.imm, ifc.op_valid, busy);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++;
            if (ifc.op_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL dropped_ack: op_valid=%b busy=%b required 0 0", ifc.op_valid, busy);
            end
        end
    endtask

`ifdef SINGLE_STEP_EN
    task automatic test_single_step();
        int issued = 0;
        int hold = 0;
        for (int a = 0; a <= int'(LAST); a++) prog[a] = {3'b001, 13'($urandom)};
        step = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 300 && done !== 1'b1; cyc++) begin
            ifc.imem_ack = 1'b0; step = 1'b0;
            if (ifc.op_valid === 1'b1) begin
                issued++; hold = 4;
            end else if (hold > 0) begin
                n_vec++;
                if (ifc.imem_req !== 1'b0 || done !== 1'b0) begin
                    n_err++; $display("FAIL step_hold: req=%b done=%b required 0 0", ifc.imem_req, done);
                end
                hold--;
                if (hold == 0) step = 1'b1;
            end
            if (ifc.imem_req === 1'b1) begin
                ifc.imem_ack = 1'b1; ifc.imem_rdata = prog[ifc.imem_addr];
            end
            @(negedge clk);
        end
        step = 1'b0; ifc.imem_ack = 1'b0;
        n_vec++;
        if (done !== 1'b1 || issued != int'(LAST) + 1) begin
            n_err++; $display("FAIL step_complete: done=%b issued=%0d required 1 %0d", done, issued, int'(LAST) + 1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_issue();
        test_multi_cycle();
        test_last_addr();
        test_back_to_back();
        test_random();
        test_reset_mid_fetch();
        test_random();
`ifdef SINGLE_STEP_EN
        test_single_step();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_issue_seq.md
Name: instr_issue_seq

Overview:
- Front-end sequencer that produces the 3-bit opcode stream consumed by control_unit.
- Fetches 16-bit instruction words from program memory over a req/ack handshake and splits each into opcode and operand fields.
- Issues one instruction per op_valid pulse and stalls on multi-cycle ALU ops (mul 3'b101, div 3'b110) until the ALU signals completion.
- Sits between program memory and the control_unit/ALU datapath of the 8-bit CPU.

Parameters:
- ADDR_W, 8, program counter / imem address width.
- LAST_ADDR, 8'hFF, address of the final instruction; the sequencer stops after issuing it.
- MC_MASK, 8'b0110_0000, one bit per opcode; bit set means the opcode is multi-cycle and waits for alu_done.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins execution at address 0 from IDLE or DONE.
- imem_req  out  1  fetch request, held high until ack.
- imem_addr  out  ADDR_W  fetch address (= pc).
- imem_ack  in  1  read data valid this cycle; ignored unless imem_req=1.
- imem_rdata  in  16  instruction word: [15:13] opcode, [12:11] rd, [10:9] rs, [8] imm_sel, [7:0] imm.
- opcode  out  3  to control_unit, registered.
- rd  out  2  destination register index.
- rs  out  2  source register index.
- imm_sel  out  1  1 = operand B is imm.
- imm  out  8  immediate value.
- op_valid  out  1  one-cycle pulse; fields are valid.
- alu_done  in  1  completion pulse for multi-cycle ops.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port rst. All state updates on the rising edge of clk.
- Reset values: pc=0, state=IDLE, imem_req=0, imem_addr=0, opcode=3'b000, rd=0, rs=0, imm_sel=0, imm=0, op_valid=0, busy=0, done=0.
- FSM states: IDLE, FETCH, ISSUE, WAIT, DONE.
- IDLE: start=1 -> FETCH with pc=0.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack=1, latch imem_rdata into the field registers -> ISSUE. Ack may arrive in the same cycle req rises; minimum FETCH time is 1 cycle.
- ISSUE: op_valid=1 for exactly one cycle, imem_req=0. Next state:
  - WAIT if MC_MASK[opcode]=1;
  - else DONE if pc==LAST_ADDR;
  - else FETCH with pc=pc+1.
- WAIT: hold the fields stable, op_valid=0. On alu_done=1 -> DONE if pc==LAST_ADDR, else FETCH with pc+1.
- alu_done outside WAIT is ignored.
- Output stability: fields remain stable from ISSUE until the next imem_ack latch.
- PC wrap: pc increments modulo 2^ADDR_W. If LAST_ADDR=2^ADDR_W-1, no wrap occurs because execution stops first.
- DONE: done=1, busy=0. start=1 -> FETCH with pc=0 and done cleared the next cycle.
- start while busy: ignored.
- rst mid-operation (including mid-FETCH with imem_req high): on the next edge, all outputs return to reset values. A pending ack is dropped.
- Throughput: single-cycle ops issue every 2 cycles when ack is immediate.
- Default: an X/unknown opcode has no special case, because all 8 encodings are legal.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined: adds input port step (1 bit) and a STEP_HOLD state.
  - After ISSUE of a single-cycle op, or after alu_done in WAIT, the FSM enters STEP_HOLD instead of FETCH/DONE.
  - It leaves STEP_HOLD on the cycle step=1, taking the transition it would otherwise have taken.
  - rst clears STEP_HOLD.
- Not defined: no step port, no STEP_HOLD state; behaviour is exactly as above.

Decomposition:
- Shared package cpu_pkg holds:
  - the opcode localparams OP_ADD..OP_CMP (3'b000..3'b111), shared with control_unit;
  - the instruction field bit positions;
  - the FSM state encoding.
- One natural sub-module: instr_field_split (combinational split of the 16-bit word into fields). The FSM, pc and registers stay in instr_issue_seq.

Test Plan:
- Reset then start; imem returns 16'h0000 at addr 0 with immediate ack -> op_valid pulses 2 cycles after start, with opcode=000, rd=0, imm=0; imem_addr then becomes 1.
- Word 16'hA1C3 (mul, rd=0, rs=0, imm_sel=1, imm=8'hC3) -> opcode=101, imm=8'hC3. FSM stays in WAIT, with no imem_req, for 5 cycles until the alu_done pulse; next fetch is at addr 1.
- LAST_ADDR=3, four add words, ack delayed 2 cycles each -> exactly 4 op_valid pulses, then done=1, busy=0. imem_addr never exceeds 3.
- Assert rst while in FETCH with imem_req=1 and an ack arriving the same cycle -> next cycle all outputs are at reset values and no op_valid occurs.
- Pulse start while busy -> ignored, pc unaffected. Pulse start in DONE -> restarts fetch at addr 0.
- With SINGLE_STEP_EN: three sub words -> after each op_valid, no imem_req until step=1. Three step pulses reach done=1.
